// File: rtl/key_tone_arbiter.sv
// Keypad-to-PWM controller: debounces scanner bitmaps, arbitrates held keys
// (last pressed wins) and sequences the amplifier shutdown/wake/enable path.
module key_tone_arbiter #(
    parameter int DEBOUNCE_SCANS = 2,
    parameter int WAKE_CYCLES    = 1000,
    parameter int N_W            = 10,
    parameter int BASE_N         = 478,
    parameter int STEP_N         = 20
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           scan,
    input  logic [15:0]    keys,
    input  logic           power,
    output logic [3:0]     btn,
    output logic [N_W-1:0] tone_n,
    output logic           tone_en,
    output logic           shutdown_l
);

    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {OFF, WAKE, IDLE, PLAY} state_t;

    state_t            state_q;
    logic [15:0]       cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       stable_q, stable_d;
    logic [15:0]       prev_q;
    logic              arb_pend_q;
    logic [WAKE_W-1:0] wake_cnt_q;
    logic [3:0]        btn_q;
    logic              tone_en_q;
    logic              shutdown_l_q;
    logic              accept;
    logic [15:0]       new_keys;
    logic [3:0]        arb_btn;
    logic              arb_valid;

    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (scan) begin
            if (keys == cand_q) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            end else begin
                cand_d = keys;
                cnt_d  = CNT_ONE;
            end
            accept = (cnt_d == CNT_MAX);
        end
        stable_d = accept ? cand_d : stable_q;
    end

    // Arbitration sees P = prev_q (stable before the accept) and S = stable_q.
    always_comb begin
        new_keys  = stable_q & ~prev_q;
        arb_valid = 1'b1;
        arb_btn   = btn_q;
        if (new_keys != 16'd0) begin
            arb_btn = lowest_idx(new_keys);
        end else if (stable_q[btn_q]) begin
            arb_btn = btn_q;
        end else if (stable_q != 16'd0) begin
            arb_btn = lowest_idx(stable_q);
        end else begin
            arb_valid = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q      <= OFF;
            cand_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= '0;
            prev_q       <= '0;
            arb_pend_q   <= 1'b0;
            wake_cnt_q   <= '0;
            btn_q        <= 4'd0;
            tone_en_q    <= 1'b0;
            shutdown_l_q <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            prev_q     <= stable_q;
            arb_pend_q <= accept;

            if (state_q != OFF && !power) begin
                state_q      <= OFF;
                tone_en_q    <= 1'b0;
                shutdown_l_q <= 1'b0;
            end else begin
                case (state_q)
                    OFF: begin
                        if (power) begin
                            state_q      <= WAKE;
                            wake_cnt_q   <= '0;
                            shutdown_l_q <= 1'b1;
                        end
                    end
                    WAKE: begin
                        if (wake_cnt_q == WAKE_LAST) state_q <= IDLE;
                        else wake_cnt_q <= wake_cnt_q + WAKE_W'(1);
                    end
                    IDLE: begin
                        if (stable_q != 16'd0) begin
                            state_q   <= PLAY;
                            btn_q     <= lowest_idx(stable_q);
                            tone_en_q <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (arb_pend_q) begin
                            if (arb_valid) begin
                                btn_q <= arb_btn;
                            end else begin
                                state_q   <= IDLE;
                                tone_en_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= OFF;
                endcase
            end
        end
    end

    assign btn        = btn_q;
    assign tone_n     = N_W'(BASE_N - STEP_N * int'(btn_q));
    assign tone_en    = tone_en_q;
    assign shutdown_l = shutdown_l_q;

endmodule

// File: doc/key_tone_arbiter.md
# key_tone_arbiter

Controller between the keypad scanner and the PWM tone generator in the audio top level. It debounces the scanner's 16-bit key bitmap across scan frames and arbitrates among simultaneously held keys, last-pressed wins. It drives the selected key index and half-period divisor into the PWM. It also sequences the amplifier power path: SHUTDOWN_L release, a wake delay, then tone enable.

## Interface
- DEBOUNCE_SCANS, 2: consecutive identical scan frames required before a key bitmap is accepted (≥1).
- WAKE_CYCLES, 1000: clk cycles between shutdown_l rising and tone output being allowed (≥1).
- N_W, 10: width of tone_n.
- BASE_N, 478: divisor for key index 0.
- STEP_N, 20: divisor decrement per key index; must satisfy BASE_N ≥ 15*STEP_N + 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_l  in  1  synchronous, active-low reset.
- scan  in  1  one-cycle pulse from the keypad scanner at end of frame; keys valid in that cycle.
- keys  in  16  pressed-key bitmap, bit i = key i held (active high).
- power  in  1  level; 1 = amplifier requested on.
- btn  out  4  selected key index.
- tone_n  out  N_W  PWM half-period divisor = BASE_N − STEP_N*btn.
- tone_en  out  1  PWM enable.
- shutdown_l  out  1  amplifier shutdown, active low.

## Operation
- Debounce registers:
  - cand (16), match_cnt (saturating), stable (16).
  - On scan with keys == cand: match_cnt increments.
  - On scan with keys ≠ cand: cand ← keys, match_cnt ← 1.
  - Accept cycle = scan cycle in which match_cnt reaches DEBOUNCE_SCANS. stable ← cand at the end of that cycle.
  - With DEBOUNCE_SCANS=1, every scan is an accept.
  - Debounce runs in all states.
- Arbitration, evaluated the cycle after an accept, with P = previous stable and S = new stable:
  - new = S & ~P. If new ≠ 0, select the lowest index set in new.
  - Else, if the current btn is set in S, keep it.
  - Else, if S ≠ 0, select the lowest index set in S.
  - Else, there is no selection.
- FSM states OFF, WAKE, IDLE, PLAY:
  - OFF: shutdown_l=0, tone_en=0. power=1 → WAKE, wake counter cleared.
  - WAKE: shutdown_l=1, tone_en=0. After WAKE_CYCLES cycles in WAKE → IDLE.
  - IDLE: shutdown_l=1, tone_en=0. stable ≠ 0 (checked every cycle) → PLAY, btn = lowest index set in stable.
  - PLAY: shutdown_l=1, tone_en=1. btn follows arbitration on each accept. An arbitration result with no selection → IDLE.
  - power=0 in WAKE, IDLE or PLAY → OFF at the next edge. This has priority over all other transitions.
- tone_n is recomputed from btn combinationally or registered alongside it. It never shows a value that is inconsistent with btn.
- btn and tone_n hold their last values in IDLE, WAKE and OFF.

## Timing
- Reset values:
  - state OFF; shutdown_l=0, tone_en=0.
  - btn=0, tone_n=BASE_N.
  - cand=0, match_cnt=0, stable=0, wake counter=0.
- Reset mid-operation takes effect at the next edge, regardless of scan or power.
- Key latency:
  - stable updates at the edge ending the accept cycle (A).
  - btn, tone_n, tone_en and state update at the edge ending cycle A+1.
- Power-up: power sampled high at edge E gives shutdown_l=1 after E. tone_en can go high no earlier than WAKE_CYCLES+1 cycles later.
- Power-down: shutdown_l=0 and tone_en=0 one edge after power is sampled low.
- A power drop during WAKE restarts the full wake count on the next power-up.
- Power falling in an accept cycle: the state goes OFF; stable still updates.
- scan held high for several cycles: each high cycle counts as one frame. The scanner guarantees single-cycle pulses.
- match_cnt saturates at DEBOUNCE_SCANS; it never wraps.

## Test plan
- Reset: rst_l=0 for 2 cycles with power=1 and keys=0xFFFF → shutdown_l=0, tone_en=0, btn=0, tone_n=478.
- Power-up with WAKE_CYCLES=8: power=1 → shutdown_l=1 one cycle later; tone_en stays 0 for ≥8 cycles; state reaches IDLE.
- Debounce:
  - keys=0x0020 on one scan, then 0x0000 → tone_en stays 0.
  - keys=0x0020 on two consecutive scans → btn=5, tone_n=378, tone_en=1 two edges after the second scan.
- Last-pressed wins:
  - Hold 0x0020, then 0x0024 for 2 scans → btn=2, tone_n=438.
  - Back to 0x0020 → btn=5, tone_n=378.
  - Then 0x0000 → tone_en=0 and state IDLE.
- Simultaneous press: keys 0x0300 from idle for 2 scans → btn=8, tone_n=318.
- Power drop mid-tone in PLAY: power=0 → next edge shutdown_l=0, tone_en=0. power=1 again with key held → tone_en returns only after the full WAKE_CYCLES, with btn unchanged.
